// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the two-port data memory arbiter.
// State encoding plus default widths and memory size.
package data_mem_arbiter_pkg;

   localparam int DEF_DATA_W    = 64;
   localparam int DEF_ADDR_W    = 64;
   localparam int DEF_MEM_BYTES = 64;

   // Each access moves one 8-byte word.
   localparam int WORD_BYTES = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin winner select.
// Purely combinational; the pointer names the favoured requester.
module rr_arbiter2 (
   input  logic req0,
   input  logic req1,
   input  logic pointer,
   output logic winner,
   output logic valid
);

   always_comb begin
      winner = 1'b0;
      valid  = req0 | req1;
      unique case (1'b1)
         (req0 & req1):  winner = pointer;
         (req1 & ~req0): winner = 1'b1;
         (req0 & ~req1): winner = 1'b0;
         default:        winner = 1'b0;
      endcase
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between two requesters.
// IDLE arbitrates and latches, ACCESS drives memory, DONE reports.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int MEM_BYTES = DEF_MEM_BYTES
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Write_Data,
   output logic              MemWrite,
   output logic              MemRead,
   input  logic [DATA_W-1:0] Read_Data
);

   localparam logic [ADDR_W-1:0] LAST_ADDR =
      ADDR_W'(MEM_BYTES - WORD_BYTES);

   state_e            state_q;
   state_e            state_d;
   logic              ptr_q;
   logic              idx_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              win;
   logic              win_vld;
   logic              in_range;

   rr_arbiter2 u_arb (
      .req0    (req0),
      .req1    (req1),
      .pointer (ptr_q),
      .winner  (win),
      .valid   (win_vld)
   );

   assign in_range = (addr_q <= LAST_ADDR);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         idx_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (win_vld) begin
                  idx_q   <= win;
                  ptr_q   <= ~win;
                  we_q    <= win ? we1 : we0;
                  addr_q  <= win ? addr1 : addr0;
                  wdata_q <= win ? wdata1 : wdata0;
               end
            end
            ACCESS: begin
               err_q <= ~in_range;
               if (in_range && !we_q) begin
                  rdata_q <= Read_Data;
               end
            end
            DONE: begin
               err_q <= 1'b0;
            end
            default: begin
               err_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      done0      = 1'b0;
      done1      = 1'b0;
      err        = 1'b0;
      Mem_Addr   = '0;
      Write_Data = '0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            gnt0       = ~idx_q;
            gnt1       = idx_q;
            Mem_Addr   = addr_q;
            Write_Data = wdata_q;
            MemRead    = ~we_q & in_range;
            // Reset kills the store in the same cycle it arrives.
            MemWrite   = we_q & in_range & reset_n;
            state_d    = DONE;
         end
         DONE: begin
            done0   = ~idx_q;
            done1   = idx_q;
            err     = err_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rdata = rdata_q;

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter DATA_W, 64, data width of requester and memory ports.
REQ-002 Parameter ADDR_W, 64, address width.
REQ-003 Parameter MEM_BYTES, 64, byte size of the attached data memory.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 req0, req1  in  1 each  access request from requester 0 / 1.
REQ-008 we0, we1  in  1 each  1 = write, 0 = read.
REQ-009 addr0, addr1  in  ADDR_W each  byte address.
REQ-010 wdata0, wdata1  in  DATA_W each  write data.
REQ-011 gnt0, gnt1  out  1 each  one-cycle pulse; request latched, requester may change inputs.
REQ-012 done0, done1  out  1 each  one-cycle pulse; access complete.
REQ-013 err  out  1  valid with done*; address out of range, no memory access made.
REQ-014 rdata  out  DATA_W  read result, valid with done* of a read.
REQ-015 Mem_Addr  out  ADDR_W; Write_Data  out  DATA_W; MemWrite, MemRead  out  1; Read_Data  in  DATA_W (combinational memory read, write on clk rise).

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and DONE; the state register is the only sequencing element besides the round-robin pointer and latch registers.
REQ-017 IDLE: if any req is high, the block SHALL select a winner, latch its we/addr/wdata, set the winner index, and move to ACCESS; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration: a single request always wins; with both requests high, the requester named by the pointer wins; after every grant the pointer SHALL point to the non-winner.
REQ-019 gnt of the winner SHALL pulse high for exactly the ACCESS cycle (one cycle after the request is sampled); a losing request SHALL be held by its requester and is served next.
REQ-020 ACCESS: Mem_Addr and Write_Data SHALL present the latched values; MemRead = latched read and in range; MemWrite = latched write and in range and reset_n.
REQ-021 In range means latched addr <= MEM_BYTES-8; otherwise err SHALL be set and both strobes SHALL stay low.
REQ-022 At the end of ACCESS, rdata SHALL capture Read_Data for an in-range read, and SHALL hold its previous value otherwise; the FSM SHALL go to DONE.
REQ-023 DONE: done of the winner SHALL pulse for one cycle with rdata/err valid; the FSM SHALL return to IDLE; requests are not sampled in DONE.
REQ-024 Latency: a request sampled in cycle N gives gnt in N+1 and done in N+2; back-to-back throughput is one access per 3 cycles.
REQ-025 Outside ACCESS, MemRead and MemWrite SHALL be 0 and Mem_Addr/Write_Data SHALL be 0.
REQ-026 err SHALL be 0 whenever no done is high; gnt0/gnt1 and done0/done1 SHALL never be high together.

Reset
REQ-027 With reset_n low at a rising edge: state = IDLE, pointer = 0, all latch registers, rdata, err, gnt*, done* = 0.
REQ-028 Reset during ACCESS SHALL suppress MemWrite in that same cycle and abort the access; no done SHALL follow.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, ACCESS, DONE) and the defaults for MEM_BYTES and DATA_W.
REQ-030 Winner selection SHALL be a sub-module rr_arbiter2 (req0, req1, pointer in; winner index and valid out; purely combinational).

Verification
REQ-031 Single read: req0, we0=0, addr0=8 in cycle N -> gnt0 at N+1 with MemRead=1, Mem_Addr=8; done0 at N+2 with rdata=0x15, err=0.
REQ-032 Conflict: req0 and req1 both high from reset (pointer 0) -> requester 0 served first, then requester 1; gnt0 at N+1, gnt1 at N+4; the next conflict is won by requester 0.
REQ-033 Write then read: req1, we1=1, addr1=16, wdata1=0xABCD -> MemWrite pulses one cycle; a following read of addr 16 returns 0xABCD.
REQ-034 Out of range: req0 read with addr0=60 -> MemRead stays 0; done0 with err=1; rdata unchanged.
REQ-035 Reset mid-write: reset_n=0 during the ACCESS cycle of a write to addr 0 -> MemWrite=0 in that cycle, no done; a subsequent read of addr 0 returns 0x7.
REQ-036 Boundary: read at addr 56 -> in range, rdata=0x6, err=0.
